ibex_fetch_req_ctrl: RTL and testbench

IBEX_FETCH_REQ_CTRL -- requirements
Module: ibex_fetch_req_ctrl

---
 rtl/ibex_fetch_req_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ibex_fetch_req_ctrl.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction fetch request controller.
// Issues word-aligned fetch requests on an OBI-style instruction bus. It keeps at most
// NUM_REQS requests granted but unanswered, and holds a request stable until it is granted.
// A branch redirects fetching. Responses to requests issued before the branch are dropped,
// and the responses that remain are passed through to the fetch FIFO.
// Optional feature: define IBEX_FETCH_DISCARD_CNT_EN to add discard_cnt_o, a saturating
// count of dropped responses.
module ibex_fetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fifo_ready_i,
    output logic        fifo_valid_o,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
`ifdef IBEX_FETCH_DISCARD_CNT_EN
    ,
    output logic [7:0]  discard_cnt_o
`endif
);

    localparam logic [3:0] MaxOut = 4'(NUM_REQS);

    typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitGntStale} state_e;

    state_e      state_q, state_d;
    logic [29:0] fetch_addr_q, fetch_addr_d;
    logic [29:0] pend_addr_q, pend_addr_d;  // branch target parked while a stale request waits
    logic [29:0] rsp_addr_q, rsp_addr_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic [3:0]  discard_q, discard_d;

    logic gnt;
    logic rvalid_eff;
    logic stale_ungnt;

    // A response is accepted only while a request is outstanding; anything else is spurious.
    assign gnt        = instr_req_o & instr_gnt_i;
    assign rvalid_eff = instr_rvalid_i & (outstanding_q != 4'd0);
    // The held request will still be granted later, so its response must also be dropped.
    assign stale_ungnt = (state_q != StIdle) & ~instr_gnt_i;

    assign instr_addr_o = {fetch_addr_q, 2'b00};
    assign busy_o       = (state_q != StIdle) | (outstanding_q != 4'd0);

    assign fifo_valid_o = rvalid_eff & (discard_q == 4'd0) & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;
    assign fifo_addr_o  = branch_i ? branch_addr_i : {rsp_addr_q, 2'b00};

    // Request FSM: request generation, fetch address and branch target handling.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pend_addr_d  = pend_addr_q;
        instr_req_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                instr_req_o = req_i & fifo_ready_i & ~branch_i & (outstanding_q < MaxOut);
                if (branch_i) begin
                    fetch_addr_d = branch_addr_i[31:2];
                end else if (instr_req_o) begin
                    if (instr_gnt_i) begin
                        fetch_addr_d = fetch_addr_q + 30'd1;
                    end else begin
                        state_d = StWaitGnt;
                    end
                end
            end
            StWaitGnt: begin
                instr_req_o = 1'b1;
                if (instr_gnt_i) begin
                    state_d      = StIdle;
                    fetch_addr_d = branch_i ? branch_addr_i[31:2] : fetch_addr_q + 30'd1;
                end else if (branch_i) begin
                    state_d     = StWaitGntStale;
                    pend_addr_d = branch_addr_i[31:2];
                end
            end
            StWaitGntStale: begin
                instr_req_o = 1'b1;
                if (instr_gnt_i) begin
                    state_d      = StIdle;
                    fetch_addr_d = branch_i ? branch_addr_i[31:2] : pend_addr_q;
                end else if (branch_i) begin
                    pend_addr_d = branch_addr_i[31:2];
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst_i) begin
            instr_req_o = 1'b0;
        end
    end

    // Outstanding, discard and response-address bookkeeping.
    always_comb begin
        outstanding_d = outstanding_q + {3'b000, gnt} - {3'b000, rvalid_eff};
        discard_d     = discard_q;
        rsp_addr_d    = rsp_addr_q;
        if (branch_i) begin
            discard_d  = outstanding_q + {3'b000, gnt} - {3'b000, rvalid_eff}
                       + {3'b000, stale_ungnt};
            rsp_addr_d = branch_addr_i[31:2];
        end else begin
            if (rvalid_eff && (discard_q != 4'd0)) begin
                discard_d = discard_q - 4'd1;
            end
            if (fifo_valid_o) begin
                rsp_addr_d = rsp_addr_q + 30'd1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            fetch_addr_q  <= 30'd0;
            pend_addr_q   <= 30'd0;
            rsp_addr_q    <= 30'd0;
            outstanding_q <= 4'd0;
            discard_q     <= 4'd0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            pend_addr_q   <= pend_addr_d;
            rsp_addr_q    <= rsp_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

`ifdef IBEX_FETCH_DISCARD_CNT_EN
    logic [7:0] discard_cnt_q;

    // Saturating count of accepted responses that were not forwarded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            discard_cnt_q <= 8'd0;
        end else if (rvalid_eff && !fifo_valid_o && (discard_cnt_q != 8'hFF)) begin
            discard_cnt_q <= discard_cnt_q + 8'd1;
        end
    end

    assign discard_cnt_o = discard_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Self-checking bench for ibex_fetch_req_ctrl: directed scenarios plus a randomized run
// against a transaction-level model (in-flight queue with stale marks, expected streams).
module tb_ibex_fetch_req_ctrl;

    localparam int NUM_REQS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] baddr = 32'd0;
    logic        fready = 1'b0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        rerr = 1'b0;
    logic        fifo_valid_o;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_err_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        busy_o;
`ifdef IBEX_FETCH_DISCARD_CNT_EN
    logic [7:0]  discard_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ibex_fetch_req_ctrl #(.NUM_REQS(NUM_REQS)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .branch_i       (branch),
        .branch_addr_i  (baddr),
        .fifo_ready_i   (fready),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (gnt),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (rvalid),
        .instr_rdata_i  (rdata),
        .instr_err_i    (rerr),
        .busy_o         (busy_o)
`ifdef IBEX_FETCH_DISCARD_CNT_EN
        ,
        .discard_cnt_o  (discard_cnt_o)
`endif
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a[5:2] == 4'hB);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req = 1'b0; branch = 1'b0; baddr = 32'd0; fready = 1'b1;
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0; rerr = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1; req = 1'b1; gnt = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (instr_req_o !== 1'b0 || busy_o !== 1'b0 || fifo_valid_o !== 1'b0
                || instr_addr_o !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got req=%b busy=%b valid=%b addr=%h, want 0 0 0 0",
                         instr_req_o, busy_o, fifo_valid_o, instr_addr_o);
            end
        end
        rst = 1'b0;
        // Mid-operation reset: a late response must be ignored.
        do_reset();
        req = 1'b1; gnt = 1'b1;
        step();
        clear_inputs();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if (fifo_valid_o !== 1'b0 || busy_o !== 1'b0 || instr_addr_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got valid=%b busy=%b addr=%h, want 0 0 0",
                     fifo_valid_o, busy_o, instr_addr_o);
        end
    endtask

    task automatic test_sequential;
        logic [31:0] a;
        do_reset();
        req = 1'b1; branch = 1'b1; baddr = 32'h100;
        #1;
        n_tests++;
        if (fifo_addr_o !== 32'h100) begin
            n_fail++;
            $display("FAIL seq_branch_fifo_addr: got %h want 00000100", fifo_addr_o);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            branch = 1'b0; gnt = 1'b1; rvalid = (k > 0);
            a = 32'h100 + 32'(4 * (k > 0 ? k - 1 : 0));
            rdata = mem_data(a); rerr = mem_err(a);
            #1;
            if (k < 3) begin
                n_tests++;
                if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100 + 32'(4 * k)) begin
                    n_fail++;
                    $display("FAIL seq_bus_addr[%0d]: got req=%b addr=%h want 1 %h", k,
                             instr_req_o, instr_addr_o, 32'h100 + 32'(4 * k));
                end
            end
            if (k > 0) begin
                n_tests++;
                if (fifo_valid_o !== 1'b1 || fifo_addr_o !== a || fifo_rdata_o !== mem_data(a)) begin
                    n_fail++;
                    $display("FAIL seq_fifo[%0d]: got v=%b addr=%h data=%h want 1 %h %h", k,
                             fifo_valid_o, fifo_addr_o, fifo_rdata_o, a, mem_data(a));
                end
            end
        end
    endtask

    task automatic test_unaligned_branch;
        do_reset();
        req = 1'b1; branch = 1'b1; baddr = 32'h102;
        #1;
        n_tests++;
        if (fifo_addr_o !== 32'h102 || instr_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL unaligned_branch_cycle: got fifo_addr=%h req=%b want 00000102 0",
                     fifo_addr_o, instr_req_o);
        end
        step();
        branch = 1'b0; gnt = 1'b1;
        #1;
        n_tests++;
        if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin
            n_fail++;
            $display("FAIL unaligned_bus_addr: got req=%b addr=%h want 1 00000100",
                     instr_req_o, instr_addr_o);
        end
        step();
        req = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = mem_data(32'h100);
        #1;
        n_tests++;
        if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h100 || fifo_rdata_o !== mem_data(32'h100)) begin
            n_fail++;
            $display("FAIL unaligned_first_rsp: got v=%b addr=%h data=%h want 1 00000100 %h",
                     fifo_valid_o, fifo_addr_o, fifo_rdata_o, mem_data(32'h100));
        end
    endtask

    task automatic test_discard;
        do_reset();
        req = 1'b1; gnt = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++;
            if (instr_req_o !== 1'b1 || instr_addr_o !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL discard_issue[%0d]: got req=%b addr=%h want 1 %h", k,
                         instr_req_o, instr_addr_o, 32'(4 * k));
            end
            step();
        end
        gnt = 1'b0; branch = 1'b1; baddr = 32'h200;
        #1;
        n_tests++;
        if (instr_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL discard_limit_req: got %b want 0", instr_req_o);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            branch = 1'b0; req = 1'b0; rvalid = 1'b1; rdata = mem_data(32'(4 * k));
            #1;
            n_tests++;
            if (fifo_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL discard_drop[%0d]: got valid=%b want 0", k, fifo_valid_o);
            end
        end
        step();
        rvalid = 1'b0; req = 1'b1; gnt = 1'b1;
        #1;
        n_tests++;
        if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin
            n_fail++;
            $display("FAIL discard_new_issue: got req=%b addr=%h want 1 00000200",
                     instr_req_o, instr_addr_o);
        end
        step();
        req = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = mem_data(32'h200);
        #1;
        n_tests++;
        if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h200 || fifo_rdata_o !== mem_data(32'h200)) begin
            n_fail++;
            $display("FAIL discard_forward: got v=%b addr=%h data=%h want 1 00000200 %h",
                     fifo_valid_o, fifo_addr_o, fifo_rdata_o, mem_data(32'h200));
        end
`ifdef IBEX_FETCH_DISCARD_CNT_EN
        n_tests++;
        if (discard_cnt_o !== 8'd2) begin
            n_fail++;
            $display("FAIL discard_cnt: got %0d want 2", discard_cnt_o);
        end
`endif
    endtask

    task automatic test_stale;
        do_reset();
        branch = 1'b1; baddr = 32'h40;
        step();
        branch = 1'b0; req = 1'b1;
        #1;
        n_tests++;
        if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h40) begin
            n_fail++;
            $display("FAIL stale_first_req: got req=%b addr=%h want 1 00000040",
                     instr_req_o, instr_addr_o);
        end
        step();
        branch = 1'b1; baddr = 32'h80;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                branch = 1'b0; req = 1'b0; fready = 1'b0;
            end
            gnt = (k == 3);
            #1;
            n_tests++;
            if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h40 || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stale_hold[%0d]: got req=%b addr=%h busy=%b want 1 00000040 1", k,
                         instr_req_o, instr_addr_o, busy_o);
            end
            step();
        end
        req = 1'b1; fready = 1'b1; gnt = 1'b1;
        #1;
        n_tests++;
        if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin
            n_fail++;
            $display("FAIL stale_target_issue: got req=%b addr=%h want 1 00000080",
                     instr_req_o, instr_addr_o);
        end
        step();
        req = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = mem_data(32'h40);
        #1;
        n_tests++;
        if (fifo_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_drop: got valid=%b want 0", fifo_valid_o);
        end
        step();
        rdata = mem_data(32'h80);
        #1;
        n_tests++;
        if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h80 || fifo_rdata_o !== mem_data(32'h80)) begin
            n_fail++;
            $display("FAIL stale_forward: got v=%b addr=%h data=%h want 1 00000080 %h",
                     fifo_valid_o, fifo_addr_o, fifo_rdata_o, mem_data(32'h80));
        end
    endtask

    task automatic test_limit;
        int grants;
        grants = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req = 1'b1; gnt = 1'b1;
            #1;
            if (instr_req_o === 1'b1) grants++;
            step();
        end
        n_tests++;
        if (grants != NUM_REQS || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_grants: got grants=%0d busy=%b want %0d 1", grants, busy_o, NUM_REQS);
        end
        fready = 1'b0; rvalid = 1'b1; rdata = mem_data(32'h0);
        #1;
        n_tests++;
        if (instr_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_no_req_at_rsp: got %b want 0", instr_req_o);
        end
        step();
        rvalid = 1'b0;
        #1;
        n_tests++;
        if (instr_req_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_fifo_not_ready: got req=%b busy=%b want 0 1", instr_req_o, busy_o);
        end
        step();
        rvalid = 1'b1; rdata = mem_data(32'h4);
        step();
        rvalid = 1'b0;
        #1;
        n_tests++;
        if (instr_req_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_drained: got req=%b busy=%b want 0 0", instr_req_o, busy_o);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        req = 1'b1; branch = 1'b1; baddr = 32'hFFFF_FFFC;
        step();
        branch = 1'b0; gnt = 1'b1;
        #1;
        n_tests++;
        if (instr_addr_o !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_first: got %h want fffffffc", instr_addr_o);
        end
        step();
        #1;
        n_tests++;
        if (instr_addr_o !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_second: got %h want 00000000", instr_addr_o);
        end
    endtask

    task automatic test_random;
        logic [31:0] q_addr[$];
        bit          q_stale[$];
        logic [31:0] exp_issue, exp_rsp, held_addr, dummy;
        bit          held, pend_stale, exp_req, st;
        int          disc;
        do_reset();
        exp_issue = 32'd0; exp_rsp = 32'd0; held = 1'b0; pend_stale = 1'b0;
        held_addr = 32'd0; disc = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            req    = ($urandom_range(0, 99) < 85);
            fready = ($urandom_range(0, 99) < 85);
            gnt    = ($urandom_range(0, 1) == 1);
            branch = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 3) == 0) baddr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else baddr = $urandom;
            rvalid = (q_addr.size() != 0) && ($urandom_range(0, 1) == 1);
            if (rvalid) begin
                rdata = mem_data(q_addr[0]); rerr = mem_err(q_addr[0]);
            end else begin
                rdata = $urandom; rerr = 1'b0;
            end
            #1;
            exp_req = held ? 1'b1 : (req && fready && !branch && (q_addr.size() < NUM_REQS));
            n_tests++;
            if (instr_req_o !== exp_req) begin
                n_fail++;
                $display("FAIL rnd_req[%0d]: got %b want %b", c, instr_req_o, exp_req);
            end
            n_tests++;
            if (busy_o !== (held || q_addr.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_busy[%0d]: got %b want %b", c, busy_o, (held || q_addr.size() != 0));
            end
            if (held) begin
                n_tests++;
                if (instr_addr_o !== held_addr) begin
                    n_fail++;
                    $display("FAIL rnd_hold_addr[%0d]: got %h want %h", c, instr_addr_o, held_addr);
                end
            end
            if (rvalid) begin
                st = q_stale.pop_front() | branch;
                dummy = q_addr.pop_front();
                n_tests++;
                if (st) begin
                    disc++;
                    if (fifo_valid_o !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rnd_drop[%0d]: got valid=%b want 0", c, fifo_valid_o);
                    end
                end else begin
                    if (fifo_valid_o !== 1'b1 || fifo_addr_o !== exp_rsp
                        || fifo_rdata_o !== mem_data(exp_rsp) || fifo_err_o !== mem_err(exp_rsp)) begin
                        n_fail++;
                        $display("FAIL rnd_fwd[%0d]: got v=%b a=%h d=%h e=%b want 1 %h %h %b", c,
                                 fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_err_o, exp_rsp,
                                 mem_data(exp_rsp), mem_err(exp_rsp));
                    end
                    exp_rsp = exp_rsp + 32'd4;
                end
            end else begin
                n_tests++;
                if (fifo_valid_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_idle_valid[%0d]: got %b want 0", c, fifo_valid_o);
                end
            end
            if (branch) begin
                n_tests++;
                if (fifo_addr_o !== baddr) begin
                    n_fail++;
                    $display("FAIL rnd_branch_fifo_addr[%0d]: got %h want %h", c, fifo_addr_o, baddr);
                end
            end
            if (exp_req && gnt) begin
                st = pend_stale | branch;
                if (!st) begin
                    n_tests++;
                    if (instr_addr_o !== exp_issue) begin
                        n_fail++;
                        $display("FAIL rnd_issue_addr[%0d]: got %h want %h", c, instr_addr_o, exp_issue);
                    end
                    exp_issue = exp_issue + 32'd4;
                end
                q_addr.push_back(instr_addr_o);
                q_stale.push_back(st);
                pend_stale = 1'b0;
            end else if (exp_req && branch) begin
                pend_stale = 1'b1;
            end
            held = exp_req && !gnt;
            held_addr = instr_addr_o;
            if (branch) begin
                foreach (q_stale[i]) q_stale[i] = 1'b1;
                exp_issue = {baddr[31:2], 2'b00};
                exp_rsp   = {baddr[31:2], 2'b00};
            end
        end
`ifdef IBEX_FETCH_DISCARD_CNT_EN
        n_tests++;
        if (discard_cnt_o !== 8'((disc > 255) ? 255 : disc)) begin
            n_fail++;
            $display("FAIL rnd_discard_cnt: got %0d want %0d", discard_cnt_o, (disc > 255) ? 255 : disc);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_unaligned_branch();
        test_discard();
        test_stale();
        test_limit();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
